// File: rtl/approx_mult_sweep_ctrl.sv
// approx_mult_sweep_ctrl: walks every signed 8x8 operand pair through an external approximate
// multiplier and accumulates error statistics against the exact product.
// Latency: first pair on mult_a/mult_b one cycle after start; done MULT_LAT+1 cycles after last pair.
// Backpressure: none in pipelined mode; with SWEEP_STREAM_EN each record stalls until rec_ready.
// Ports: clk, rst_n (async, active-low); start/abort in; busy/done out; mult_a/mult_b out,
//        mult_out in; err_cnt, max_abs_err, worst_a/worst_b, sum_abs_err, err_sum statistics out.
// Optional macro SWEEP_STREAM_EN: one pair at a time, each result emitted as a per-pair record
//        on rec_valid/rec_ready with rec_a, rec_b, rec_out, rec_err.
module approx_mult_sweep_ctrl #(
  parameter int MULT_LAT = 0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               abort,
  output logic               busy,
  output logic               done,
  output logic signed [7:0]  mult_a,
  output logic signed [7:0]  mult_b,
  input  logic signed [15:0] mult_out,
  output logic [16:0]        err_cnt,
  output logic [15:0]        max_abs_err,
  output logic signed [7:0]  worst_a,
  output logic signed [7:0]  worst_b,
  output logic [31:0]        sum_abs_err,
  output logic signed [32:0] err_sum
`ifdef SWEEP_STREAM_EN
  ,
  output logic               rec_valid,
  input  logic               rec_ready,
  output logic signed [7:0]  rec_a,
  output logic signed [7:0]  rec_b,
  output logic signed [15:0] rec_out,
  output logic signed [16:0] rec_err
`endif
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  localparam logic signed [7:0] OP_MIN = 8'sh80;
  localparam logic signed [7:0] OP_MAX = 8'sh7f;

  state_t             state;
  logic signed [7:0]  cap_a;
  logic signed [7:0]  cap_b;
  logic               cap_vld;
  logic signed [15:0] ext_a;
  logic signed [15:0] ext_b;
  logic signed [15:0] exact;
  logic signed [16:0] err;
  logic [15:0]        abs_err;
  logic               accept;
  logic               cap_en;
  logic               on_last;

  assign accept  = (state == IDLE) && start && !abort;
  // A capture landing on the abort edge belongs to a discarded in-flight pair.
  assign cap_en  = cap_vld && !(busy && abort);
  assign on_last = (mult_a == OP_MAX) && (mult_b == OP_MAX);

  always_comb begin
    ext_a   = {{8{cap_a[7]}}, cap_a};
    ext_b   = {{8{cap_b[7]}}, cap_b};
    exact   = ext_a * ext_b;
    err     = {mult_out[15], mult_out} - {exact[15], exact};
    // |err| never exceeds 49152, so the low 16 bits of the negation are exact.
    abs_err = err[16] ? (~err[15:0] + 16'd1) : err[15:0];
  end

  // Statistics: cleared on an accepted start, otherwise held between sweeps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt     <= '0;
      max_abs_err <= '0;
      worst_a     <= '0;
      worst_b     <= '0;
      sum_abs_err <= '0;
      err_sum     <= '0;
    end else if (accept) begin
      err_cnt     <= '0;
      max_abs_err <= '0;
      worst_a     <= '0;
      worst_b     <= '0;
      sum_abs_err <= '0;
      err_sum     <= '0;
    end else if (cap_en) begin
      if (err != 17'sd0) err_cnt <= err_cnt + 17'd1;
      sum_abs_err <= sum_abs_err + {16'd0, abs_err};
      err_sum     <= err_sum + {{16{err[16]}}, err};
      // Strictly greater keeps the first pair that reached the maximum.
      if (abs_err > max_abs_err) begin
        max_abs_err <= abs_err;
        worst_a     <= cap_a;
        worst_b     <= cap_b;
      end
    end
  end

`ifndef SWEEP_STREAM_EN
  logic iss_vld;
  logic iss_last;
  logic cap_last;

  assign iss_vld  = (state == RUN);
  assign iss_last = iss_vld && on_last;

  // Operand/valid delay line so each product is scored against the pair that produced it.
  if (MULT_LAT == 0) begin : g_direct
    assign cap_a    = mult_a;
    assign cap_b    = mult_b;
    assign cap_vld  = iss_vld;
    assign cap_last = iss_last;
  end else begin : g_delay
    logic signed [7:0]   a_dly [MULT_LAT];
    logic signed [7:0]   b_dly [MULT_LAT];
    logic [MULT_LAT-1:0] vld_dly;
    logic [MULT_LAT-1:0] last_dly;
    logic                flush;

    assign flush = busy && abort;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int i = 0; i < MULT_LAT; i++) begin
          a_dly[i] <= '0;
          b_dly[i] <= '0;
        end
        vld_dly  <= '0;
        last_dly <= '0;
      end else begin
        a_dly[0]    <= mult_a;
        b_dly[0]    <= mult_b;
        vld_dly[0]  <= iss_vld && !flush;
        last_dly[0] <= iss_last;
        for (int i = 1; i < MULT_LAT; i++) begin
          a_dly[i]    <= a_dly[i-1];
          b_dly[i]    <= b_dly[i-1];
          vld_dly[i]  <= vld_dly[i-1] && !flush;
          last_dly[i] <= last_dly[i-1];
        end
      end
    end

    assign cap_a    = a_dly[MULT_LAT-1];
    assign cap_b    = b_dly[MULT_LAT-1];
    assign cap_vld  = vld_dly[MULT_LAT-1];
    assign cap_last = last_dly[MULT_LAT-1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      mult_a <= '0;
      mult_b <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            state  <= RUN;
            busy   <= 1'b1;
            mult_a <= OP_MIN;
            mult_b <= OP_MIN;
          end
        end
        default: begin
          if (abort) begin
            state  <= IDLE;
            busy   <= 1'b0;
            mult_a <= '0;
            mult_b <= '0;
          end else begin
            if (state == RUN) begin
              if (on_last) begin
                state  <= DRAIN;
                mult_a <= '0;
                mult_b <= '0;
              end else begin
                mult_b <= mult_b + 8'sd1;
                if (mult_b == OP_MAX) mult_a <= mult_a + 8'sd1;
              end
            end
            // With MULT_LAT=0 the last capture coincides with the last issue, skipping DRAIN.
            if (cap_vld && cap_last) begin
              state <= IDLE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
          end
        end
      endcase
    end
  end
`else
  localparam logic [1:0] LAT_CNT = 2'(MULT_LAT);
  logic [1:0] wait_cnt;

  // The pair is held on the bus until its record is accepted, so no delay line is needed.
  assign cap_a   = mult_a;
  assign cap_b   = mult_b;
  assign cap_vld = (state == RUN) && !rec_valid && (wait_cnt == LAT_CNT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      mult_a    <= '0;
      mult_b    <= '0;
      wait_cnt  <= '0;
      rec_valid <= 1'b0;
      rec_a     <= '0;
      rec_b     <= '0;
      rec_out   <= '0;
      rec_err   <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            state     <= RUN;
            busy      <= 1'b1;
            mult_a    <= OP_MIN;
            mult_b    <= OP_MIN;
            wait_cnt  <= '0;
            rec_valid <= 1'b0;
          end
        end
        default: begin
          if (abort) begin
            state     <= IDLE;
            busy      <= 1'b0;
            mult_a    <= '0;
            mult_b    <= '0;
            wait_cnt  <= '0;
            rec_valid <= 1'b0;
          end else if (!rec_valid) begin
            if (cap_vld) begin
              rec_valid <= 1'b1;
              rec_a     <= mult_a;
              rec_b     <= mult_b;
              rec_out   <= mult_out;
              rec_err   <= err;
              if (on_last) state <= DRAIN;
            end else if (state == RUN) begin
              wait_cnt <= wait_cnt + 2'd1;
            end
          end else if (rec_ready) begin
            rec_valid <= 1'b0;
            wait_cnt  <= '0;
            if (state == DRAIN) begin
              state  <= IDLE;
              busy   <= 1'b0;
              done   <= 1'b1;
              mult_a <= '0;
              mult_b <= '0;
            end else begin
              mult_b <= mult_b + 8'sd1;
              if (mult_b == OP_MAX) mult_a <= mult_a + 8'sd1;
            end
          end
        end
      endcase
    end
  end
`endif

endmodule

// File: tb/tb_approx_mult_sweep_ctrl.sv
// tb_approx_mult_sweep_ctrl: three sweep controllers side by side (MULT_LAT 0/2/1) driven by a
// zero multiplier, a 2-cycle exact multiplier and a 1-cycle randomized-error multiplier.
// Expected statistics come from constants and a whole-sweep arithmetic model of the error table.
module tb_approx_mult_sweep_ctrl;

  typedef struct {
    longint cnt;
    longint sabs;
    longint sum;
    longint mx;
    longint wa;
    longint wb;
  } stats_t;

  logic clk = 1'b0;
  logic rst_n;
  logic start;
  logic abort;

  logic               busy_w      [3];
  logic               done_w      [3];
  logic signed [7:0]  ma_w        [3];
  logic signed [7:0]  mb_w        [3];
  logic signed [15:0] mo_w        [3];
  logic [16:0]        err_cnt_w   [3];
  logic [15:0]        max_w       [3];
  logic signed [7:0]  wa_w        [3];
  logic signed [7:0]  wb_w        [3];
  logic [31:0]        sabs_w      [3];
  logic signed [32:0] esum_w      [3];
`ifdef SWEEP_STREAM_EN
  logic               rec_ready;
  logic               rec_valid_w [3];
  logic signed [7:0]  rec_a_w     [3];
  logic signed [7:0]  rec_b_w     [3];
  logic signed [15:0] rec_out_w   [3];
  logic signed [16:0] rec_err_w   [3];
`endif

  logic signed [15:0] out_tab [65536];
  logic signed [15:0] d1, d2, t1;
  int done_n [3];
  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    approx_mult_sweep_ctrl #(.MULT_LAT(g == 0 ? 0 : (g == 1 ? 2 : 1))) u_dut (
      .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
      .busy(busy_w[g]), .done(done_w[g]),
      .mult_a(ma_w[g]), .mult_b(mb_w[g]), .mult_out(mo_w[g]),
      .err_cnt(err_cnt_w[g]), .max_abs_err(max_w[g]),
      .worst_a(wa_w[g]), .worst_b(wb_w[g]),
      .sum_abs_err(sabs_w[g]), .err_sum(esum_w[g])
`ifdef SWEEP_STREAM_EN
      , .rec_valid(rec_valid_w[g]), .rec_ready(rec_ready),
      .rec_a(rec_a_w[g]), .rec_b(rec_b_w[g]),
      .rec_out(rec_out_w[g]), .rec_err(rec_err_w[g])
`endif
    );
  end

  function automatic int kidx(logic signed [7:0] a, logic signed [7:0] b);
    return (int'(a) + 128) * 256 + (int'(b) + 128);
  endfunction

  // Multiplier stubs.
  assign mo_w[0] = '0;
  always @(posedge clk) begin
    d1 <= 16'(int'(ma_w[1]) * int'(mb_w[1]));
    d2 <= d1;
    t1 <= out_tab[kidx(ma_w[2], mb_w[2])];
  end
  assign mo_w[1] = d2;
  assign mo_w[2] = t1;

  always @(negedge clk) for (int i = 0; i < 3; i++) if (done_w[i]) done_n[i]++;

  task automatic check(string tag, longint got, longint exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Statistics over the first n pairs of the sweep order, for stub kind 0=zero 1=exact 2=table.
  function automatic stats_t model(int kind, int n);
    stats_t s;
    int a, b, p, o, e, ae;
    s = '{0, 0, 0, 0, 0, 0};
    for (int k = 0; k < n; k++) begin
      a = k / 256 - 128;
      b = k % 256 - 128;
      p = a * b;
      o = (kind == 0) ? 0 : ((kind == 1) ? p : int'(out_tab[k]));
      e = o - p;
      ae = (e < 0) ? -e : e;
      if (e != 0) s.cnt++;
      s.sabs += ae;
      s.sum += e;
      if (ae > s.mx) begin
        s.mx = ae;
        s.wa = a;
        s.wb = b;
      end
    end
    return s;
  endfunction

  task automatic check_stats(string tag, int d, stats_t s);
    check({tag, "_err_cnt"}, longint'(err_cnt_w[d]), s.cnt);
    check({tag, "_sum_abs"}, longint'(sabs_w[d]), s.sabs);
    check({tag, "_err_sum"}, longint'(esum_w[d]), s.sum);
    check({tag, "_max_abs"}, longint'(max_w[d]), s.mx);
    check({tag, "_worst_a"}, longint'(wa_w[d]), s.wa);
    check({tag, "_worst_b"}, longint'(wb_w[d]), s.wb);
  endtask

  task automatic check_idle_zero(string tag);
    stats_t z;
    z = '{0, 0, 0, 0, 0, 0};
    for (int d = 0; d < 3; d++) begin
      check($sformatf("%s_busy%0d", tag, d), longint'(busy_w[d]), 0);
      check($sformatf("%s_done%0d", tag, d), longint'(done_w[d]), 0);
      check($sformatf("%s_ma%0d", tag, d), longint'(ma_w[d]), 0);
      check($sformatf("%s_mb%0d", tag, d), longint'(mb_w[d]), 0);
      check_stats($sformatf("%s_u%0d", tag, d), d, z);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int a, b, e, r, k, cyc, w;
    int done_at [3];
    stats_t zs, ex;

    for (int i = 0; i < 65536; i++) begin
      a = i / 256 - 128;
      b = i % 256 - 128;
      r = int'($urandom_range(0, 9));
      if (r < 4) e = 0;
      else if (r < 9) e = int'($urandom_range(0, 400)) - 200;
      else e = int'($urandom_range(0, 6000)) - 3000;
      out_tab[i] = 16'(a * b + e);
    end
    // Several equal-magnitude outliers: the first one in sweep order must be reported.
    for (int i = 0; i < 6; i++) begin
      k = int'($urandom_range(0, 65535));
      out_tab[k] = 16'((k / 256 - 128) * (k % 256 - 128) + ((i % 2) ? -16000 : 16000));
    end

    rst_n = 1'b0;
    start = 1'b0;
    abort = 1'b0;
`ifdef SWEEP_STREAM_EN
    rec_ready = 1'b0;
`endif
    repeat (3) tick();
    check_idle_zero("reset");
    rst_n = 1'b1;
    tick();

`ifdef SWEEP_STREAM_EN
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int rr = 0; rr < 20; rr++) begin
      w = 0;
      while (!rec_valid_w[0] && w < 50) begin
        tick();
        w++;
      end
      check("rec_valid_wait", longint'(rec_valid_w[0]), 1);
      a = rr / 256 - 128;
      b = rr % 256 - 128;
      for (int s = 0; s <= ((rr == 7) ? 10 : 0); s++) begin
        if (s > 0) tick();
        check($sformatf("rec%0d_valid", rr), longint'(rec_valid_w[0]), 1);
        check($sformatf("rec%0d_a", rr), longint'(rec_a_w[0]), a);
        check($sformatf("rec%0d_b", rr), longint'(rec_b_w[0]), b);
        check($sformatf("rec%0d_out", rr), longint'(rec_out_w[0]), 0);
        check($sformatf("rec%0d_err", rr), longint'(rec_err_w[0]), -(a * b));
      end
      rec_ready = 1'b1;
      tick();
      rec_ready = 1'b0;
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("stream_abort_busy", longint'(busy_w[0]), 0);
    check("stream_abort_done", done_n[0], 0);
`else
    // Abort has priority over start in IDLE.
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    check("abort_prio_busy", longint'(busy_w[0]), 0);
    check("abort_prio_ma", longint'(ma_w[0]), 0);

    // Abort during cycle 100 of a sweep.
    start = 1'b1;
    tick();
    start = 1'b0;
    check("c1_busy", longint'(busy_w[0]), 1);
    check("c1_ma", longint'(ma_w[0]), -128);
    check("c1_mb", longint'(mb_w[0]), -128);
    repeat (99) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    for (int d = 0; d < 3; d++) begin
      check($sformatf("abort_busy%0d", d), longint'(busy_w[d]), 0);
      check($sformatf("abort_ma%0d", d), longint'(ma_w[d]), 0);
      check($sformatf("abort_mb%0d", d), longint'(mb_w[d]), 0);
    end
    repeat (3) tick();
    check_stats("abort_u0", 0, model(0, 99));
    check_stats("abort_u1", 1, model(1, 97));
    check_stats("abort_u2", 2, model(2, 98));
    for (int d = 0; d < 3; d++) check($sformatf("abort_nodone%0d", d), done_n[d], 0);

    // Full sweep; a start pulse mid-sweep must be ignored.
    start = 1'b1;
    tick();
    start = 1'b0;
    check("sweep_clr_u0", longint'(err_cnt_w[0]), 0);
    check("sweep_clr_u2", longint'(err_cnt_w[2]), 0);
    done_at = '{-1, -1, -1};
    cyc = 1;
    while (cyc < 65700 && (done_at[0] < 0 || done_at[1] < 0 || done_at[2] < 0)) begin
      for (int d = 0; d < 3; d++) if (done_w[d] && done_at[d] < 0) done_at[d] = cyc;
      if (cyc == 2) begin
        check("c2_ma", longint'(ma_w[0]), -128);
        check("c2_mb", longint'(mb_w[0]), -127);
      end
      if (cyc == 257) begin
        check("c257_ma", longint'(ma_w[0]), -127);
        check("c257_mb", longint'(mb_w[0]), -128);
      end
      if (cyc == 40000) check("mid_busy", longint'(busy_w[2]), 1);
      start = (cyc == 30000);
      tick();
      cyc++;
    end
    start = 1'b0;
    check("done_cycle_u0", done_at[0], 65537);
    check("done_cycle_u1", done_at[1], 65539);
    check("done_cycle_u2", done_at[2], 65538);
    tick();
    for (int d = 0; d < 3; d++) begin
      check($sformatf("done_pulses%0d", d), done_n[d], 1);
      check($sformatf("end_busy%0d", d), longint'(busy_w[d]), 0);
      check($sformatf("end_ma%0d", d), longint'(ma_w[d]), 0);
    end
    zs = '{65025, 268435456, -16384, 16384, -128, -128};
    ex = '{0, 0, 0, 0, 0, 0};
    check_stats("sweep_u0", 0, zs);
    check_stats("sweep_u1", 1, ex);
    check_stats("sweep_u2", 2, model(2, 65536));
    repeat (5) tick();
    check_stats("hold_u0", 0, zs);
    check("hold_done", longint'(done_w[0]), 0);

    // Asynchronous reset at cycle 5000 of a sweep.
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (4999) tick();
    #2;
    rst_n = 1'b0;
    #1;
    check_idle_zero("midreset");
    tick();
    rst_n = 1'b1;
    repeat (20) tick();
    for (int d = 0; d < 3; d++) begin
      check($sformatf("post_rst_done%0d", d), done_n[d], 1);
      check($sformatf("post_rst_busy%0d", d), longint'(busy_w[d]), 0);
    end
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
